fifo_rr_drain: RTL and testbench

Round-robin drain stage that sits directly downstream of a bank of fall-through FIFOs (DWIDTH-wide, empty/rd_en interface) and merges them into a single registered valid/ready stream for the consuming engine. Each cycle the output register can accept data, the stage pops at most one FIFO head, records its source index, and presents it one cycle later. Bounded bursting per source, up to BURST_LEN consecutive pops, amortises switching while guaranteeing fairness.

---
 rtl/fifo_rr_drain.sv | 101 ++++++++++
 tb/tb_fifo_rr_drain.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_drain.sv
// fifo_rr_drain: merges a bank of fall-through FIFOs into one registered
// valid/ready stream, round-robin with bounded per-source bursts.
module fifo_rr_drain #(
    parameter int DWIDTH      = 16,
    parameter int N_FIFO      = 4,
    parameter int IDX_WIDTH   = 2,
    parameter int BURST_LEN   = 4,
    parameter int BURST_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_FIFO*DWIDTH-1:0] fifo_dout,
    input  logic [N_FIFO-1:0]        fifo_empty,
    output logic [N_FIFO-1:0]        fifo_rd_en,
    output logic [DWIDTH-1:0]        out_data,
    output logic [IDX_WIDTH-1:0]     out_src,
    output logic                     out_valid,
    input  logic                     out_ready
);
    logic [DWIDTH-1:0]      out_data_q, out_data_d;
    logic [IDX_WIDTH-1:0]   out_src_q, out_src_d;
    logic                   out_valid_q, out_valid_d;
    logic [IDX_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic [BURST_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
    logic                   load_en, stick, hi_found, lo_found, grant_vld;
    logic [IDX_WIDTH-1:0]   hi_idx, lo_idx, grant;
    logic [DWIDTH-1:0]      grant_data;

    assign load_en = !out_valid_q || out_ready;
    assign stick   = (burst_cnt_q != '0) && (burst_cnt_q < BURST_WIDTH'(BURST_LEN))
                     && !fifo_empty[last_grant_q];

    // Indices above last_grant win first; the wrapped set (including last_grant) is the fallback.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = N_FIFO - 1; i >= 0; i--) begin
            if (!fifo_empty[i] && i > int'(last_grant_q)) begin
                hi_found = 1'b1;
                hi_idx   = IDX_WIDTH'(i);
            end
            if (!fifo_empty[i] && i <= int'(last_grant_q)) begin
                lo_found = 1'b1;
                lo_idx   = IDX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        grant      = stick ? last_grant_q : (hi_found ? hi_idx : lo_idx);
        grant_vld  = load_en && !reset && (stick || hi_found || lo_found);
        grant_data = '0;
        fifo_rd_en = '0;
        for (int i = 0; i < N_FIFO; i++) begin
            if (grant == IDX_WIDTH'(i)) begin
                grant_data    = fifo_dout[i*DWIDTH +: DWIDTH];
                fifo_rd_en[i] = grant_vld;
            end
        end
    end

    always_comb begin
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        if (grant_vld) begin
            out_data_d   = grant_data;
            out_src_d    = grant;
            out_valid_d  = 1'b1;
            last_grant_d = grant;
            burst_cnt_d  = stick ? burst_cnt_q + 1'b1 : BURST_WIDTH'(1);
        end else if (load_en) begin
            out_valid_d = 1'b0;
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q   <= '0;
            out_src_q    <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= IDX_WIDTH'(N_FIFO - 1);
            burst_cnt_q  <= '0;
        end else begin
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_fifo_rr_drain.sv
// tb_fifo_rr_drain: drives queue-modelled FIFOs into fifo_rr_drain and checks
// pops and outputs against a round-robin/burst reference model.
module tb_fifo_rr_drain;
    localparam int DW = 16;
    localparam int NF = 4;
    localparam int BL = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NF*DW-1:0] fifo_dout;
    logic [NF-1:0]    fifo_empty;
    logic [NF-1:0]    fifo_rd_en;
    logic [DW-1:0]    out_data;
    logic [1:0]       out_src;
    logic             out_valid;
    logic             out_ready = 1'b0;

    fifo_rr_drain #(.DWIDTH(DW), .N_FIFO(NF), .IDX_WIDTH(2), .BURST_LEN(BL), .BURST_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_src(out_src),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] q [NF][$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [1:0]    m_src;
    int            m_last, m_burst;
    logic [NF-1:0] obs_rd, exp_rd;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic drive_heads();
        for (int i = 0; i < NF; i++) begin
            fifo_empty[i] = (q[i].size() == 0);
            fifo_dout[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : 16'hDEAD;
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = '0;
        m_last  = NF - 1;
        m_burst = 0;
    endtask

    task automatic step();
        int g, nb, j;
        #2;
        obs_rd = fifo_rd_en;
        g = -1;
        nb = 0;
        if (!m_valid || out_ready) begin
            if (m_burst >= 1 && m_burst < BL && q[m_last].size() != 0) begin
                g = m_last;
                nb = m_burst + 1;
            end else begin
                for (int k = 1; k <= NF; k++) begin
                    j = (m_last + k) % NF;
                    if (g < 0 && q[j].size() != 0) begin
                        g = j;
                        nb = 1;
                    end
                end
            end
        end
        exp_rd = (g >= 0) ? NF'(1 << g) : '0;
        @(posedge clk);
        if (!m_valid || out_ready) begin
            if (g >= 0) begin
                m_data  = q[g].pop_front();
                m_src   = 2'(g);
                m_valid = 1'b1;
                m_last  = g;
                m_burst = nb;
            end else begin
                m_valid = 1'b0;
                m_burst = 0;
            end
        end
        #1 drive_heads();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < NF; i++) q[i].delete();
        drive_heads();
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        q[0].push_back(16'h1111);
        drive_heads();
        model_reset();
        #2;
        n_checks++;
        if (fifo_rd_en !== 4'b0 || out_valid !== 1'b0 || out_data !== 16'h0 || out_src !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_init rd_en=%b valid=%b data=%h src=%0d, expected 0000/0/0000/0", fifo_rd_en, out_valid, out_data, out_src);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (fifo_rd_en !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_rd_en got %b expected 0000", fifo_rd_en);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (obs_rd !== exp_rd || {out_valid, out_src, out_data} !== {m_valid, m_src, m_data}) begin
            n_fail++;
            $display("FAIL reset_first_pop rd=%b v=%b s=%0d d=%h, expected rd=%b v=%b s=%0d d=%h", obs_rd, out_valid, out_src, out_data, exp_rd, m_valid, m_src, m_data);
        end
        q[0].push_back(16'h2222);
        drive_heads();
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_src !== 2'd0 || fifo_rd_en !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_async v=%b d=%h s=%0d rd=%b, expected 0/0000/0/0000", out_valid, out_data, out_src, fifo_rd_en);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (fifo_rd_en !== 4'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold rd=%b v=%b, expected 0000/0", fifo_rd_en, out_valid);
        end
        apply_reset();
    endtask

    task automatic test_single_source();
        logic [DW-1:0] words [3];
        words = '{16'hA0A0, 16'hB1B1, 16'hC2C2};
        apply_reset();
        for (int i = 0; i < 3; i++) q[2].push_back(words[i]);
        drive_heads();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (obs_rd !== 4'b0100 || out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== words[i]) begin
                n_fail++;
                $display("FAIL single_%0d rd=%b v=%b s=%0d d=%h, expected 0100/1/2/%h", i, obs_rd, out_valid, out_src, out_data, words[i]);
            end
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || obs_rd !== 4'b0) begin
            n_fail++;
            $display("FAIL single_drained v=%b rd=%b, expected 0/0000", out_valid, obs_rd);
        end
    endtask

    task automatic test_rr_burst();
        int exp_src [12];
        exp_src = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
        apply_reset();
        for (int i = 0; i < NF; i++)
            for (int k = 0; k < 3; k++) q[i].push_back(16'(i * 256 + k));
        drive_heads();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_src !== 2'(exp_src[i]) || out_data !== m_data || obs_rd !== exp_rd) begin
                n_fail++;
                $display("FAIL rr_burst_%0d v=%b s=%0d d=%h rd=%b, expected 1/%0d/%h/%b", i, out_valid, out_src, out_data, obs_rd, exp_src[i], m_data, exp_rd);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] hd;
        logic [1:0]    hs;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            q[0].push_back(16'h5000 + 16'(k));
            q[1].push_back(16'h6000 + 16'(k));
        end
        drive_heads();
        out_ready = 1'b1;
        step();
        hd = out_data;
        hs = out_src;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h5000 || out_src !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_first v=%b s=%0d d=%h, expected 1/0/5000", out_valid, out_src, out_data);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (obs_rd !== 4'b0 || out_valid !== 1'b1 || out_data !== hd || out_src !== hs) begin
                n_fail++;
                $display("FAIL bp_hold_%0d rd=%b v=%b s=%0d d=%h, expected 0000/1/%0d/%h", i, obs_rd, out_valid, out_src, out_data, hs, hd);
            end
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (obs_rd !== 4'b0001 || out_valid !== 1'b1 || out_data !== 16'h5001 || out_src !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_release rd=%b v=%b s=%0d d=%h, expected 0001/1/0/5001", obs_rd, out_valid, out_src, out_data);
        end
    endtask

    task automatic test_wrap_skip();
        apply_reset();
        for (int k = 0; k < 3; k++) q[3].push_back(16'h3300 + 16'(k));
        drive_heads();
        out_ready = 1'b1;
        step();
        step();
        n_checks++;
        if (out_src !== 2'd3 || out_data !== 16'h3301) begin
            n_fail++;
            $display("FAIL wrap_setup s=%0d d=%h, expected 3/3301", out_src, out_data);
        end
        q[2].push_back(16'h2200);
        drive_heads();
        step();
        n_checks++;
        if (obs_rd !== 4'b0100 || out_src !== 2'd2 || out_data !== 16'h2200) begin
            n_fail++;
            $display("FAIL wrap_skip rd=%b s=%0d d=%h, expected 0100/2/2200", obs_rd, out_src, out_data);
        end
    endtask

    task automatic test_empty_after_burst();
        apply_reset();
        q[1].push_back(16'h1100);
        q[3].push_back(16'h3300);
        q[3].push_back(16'h3301);
        drive_heads();
        out_ready = 1'b1;
        step();
        n_checks++;
        if (obs_rd !== 4'b0010 || out_src !== 2'd1) begin
            n_fail++;
            $display("FAIL eab_first rd=%b s=%0d, expected 0010/1", obs_rd, out_src);
        end
        step();
        n_checks++;
        if (obs_rd !== 4'b1000 || out_src !== 2'd3 || out_data !== 16'h3300) begin
            n_fail++;
            $display("FAIL eab_switch rd=%b s=%0d d=%h, expected 1000/3/3300", obs_rd, out_src, out_data);
        end
        q[0].push_back(16'h0A00);
        drive_heads();
        step();
        n_checks++;
        if (obs_rd !== 4'b1000 || out_src !== 2'd3 || out_data !== 16'h3301) begin
            n_fail++;
            $display("FAIL eab_burst_restart rd=%b s=%0d d=%h, expected 1000/3/3301", obs_rd, out_src, out_data);
        end
    endtask

    task automatic test_random();
        int f;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if (c < 500 && $urandom_range(0, 2) != 0) begin
                f = $urandom_range(0, NF - 1);
                if (q[f].size() < 8) q[f].push_back(16'($urandom));
                drive_heads();
            end
            out_ready = (c >= 560) || ($urandom_range(0, 3) != 0);
            step();
            n_checks++;
            if (obs_rd !== exp_rd || {out_valid, out_src, out_data} !== {m_valid, m_src, m_data}) begin
                n_fail++;
                $display("FAIL random_c%0d rd=%b v=%b s=%0d d=%h, expected rd=%b v=%b s=%0d d=%h", c, obs_rd, out_valid, out_src, out_data, exp_rd, m_valid, m_src, m_data);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NF; i++) q[i].delete();
        drive_heads();
        test_reset();
        test_single_source();
        test_rr_burst();
        test_backpressure();
        test_wrap_skip();
        test_empty_after_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
